up_dn_cmd_gen: RTL and testbench
================================

// Module: up_dn_cmd_gen
// PURPOSE
//  Upstream command stage for the 5-bit saturating up/down counter.
//  - Turns three raw pushbuttons (up, down, load) and a 5-bit switch bank into clean, single-cycle commands.
//  - Per button: 2-flop synchroniser, then debounce, then rising-edge pulse generator.
//  - Its Up/Down/Load/IN outputs drive the counter's like-named inputs directly, on the same CLK.
// PARAMETERS
//  DB_CYCLES      16   consecutive cycles a synchronised input must differ from its debounced state before that state flips (>=2)
//  REPEAT_DELAY   1000 cycles from first pulse to first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD  250  cycles between later auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  CLK     in   1  system clock, rising edge
//  RST     in   1  asynchronous reset, active-high
//  BTN_UP  in   1  raw up button, asynchronous, 1 = pressed
//  BTN_DN  in   1  raw down button, asynchronous, 1 = pressed
//  BTN_LD  in   1  raw load button, asynchronous, 1 = pressed
//  SW_IN   in   5  raw switch bank, asynchronous
//  Up      out  1  one-cycle increment command
//  Down    out  1  one-cycle decrement command
//  Load    out  1  one-cycle load command
//  IN      out  5  load value; valid whenever Load=1
// BEHAVIOUR
//  - Reset: RST=1 immediately clears all internal state and outputs (sync flops, debounced states, debounce/repeat counters, Up, Down, Load, IN=0).
//  - Sync: each BTN_* and every SW_IN bit passes through 2 flops (s1, s2).
//  - Debounce, per button: cnt increments while s2 != stable and clears when s2 == stable.
//    - When cnt == DB_CYCLES-1 and s2 != stable: stable <= s2 and cnt <= 0.
//    - A glitch shorter than DB_CYCLES cycles never changes stable.
//  - Edge: a button's request is high for exactly one cycle, the cycle after its stable 0->1. Nothing is generated on release.
//  - Latency: the first CLK edge sampling BTN high is edge 0. Output pulse is high after edge 2+DB_CYCLES+1 (all outputs registered).
//  - Priority: Load > Down > Up, matching the counter. Up, Down and Load are mutually exclusive (one-hot or zero).
//    - Lower-priority requests in the same cycle are dropped, not queued.
//  - IN: updated from synchronised SW_IN (s2) on the same edge that sets Load=1. Held unchanged at all other times.
//  - A held button produces no further pulses (unless AUTO_REPEAT_EN). A new pulse needs release (stable->0) then press again.
//  - Reset mid-debounce or mid-repeat: all progress is lost.
//    - A button still held when RST deasserts is treated as a new press: one pulse after full latency.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: Up/Down auto-repeat while stable=1.
//    - First repeat pulse comes REPEAT_DELAY cycles after the edge pulse, then one every REPEAT_PERIOD cycles.
//    - The repeat counter clears when stable->0.
//    - Repeat pulses obey the same priority and drop rules. Load never repeats.
//  AUTO_REPEAT_EN undefined: no repeat logic is synthesised. Exactly one pulse per press.
// STRUCTURE
//  Shared header up_dn_defs.vh holds:
//    - CNT_W = 5 (counter/IN width)
//    - command priority encoding: CMD_NONE, CMD_UP, CMD_DN, CMD_LD
//  Sub-module btn_debounce: synchroniser, debounce counter, stable flag and rise pulse.
//    - Parameter DB_CYCLES; outputs stable and rise.
//    - Instantiated 3 times.
//  Top level holds: SW_IN synchroniser, optional repeat timers, priority encoder, output registers.
// TESTING  (bench: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, CLK period 10ns)
//  1. RST=1 with BTN_*=1, SW_IN=5'h1F -> Up=Down=Load=0 and IN=0 immediately; they stay 0 while RST=1.
//  2. BTN_UP high for 3 cycles, then low -> no Up pulse ever. Held 10 cycles -> exactly one Up pulse, 7 edges after the first sampled high.
//  3. SW_IN=5'h0F, press BTN_LD -> Load=1 for one cycle with IN=5'h0F that same cycle. IN stays 0F after SW_IN changes to 5'h03.
//  4. BTN_UP and BTN_DN rise on the same edge -> one Down pulse, no Up pulse. Then BTN_LD with BTN_DN held -> Load only.
//  5. AUTO_REPEAT_EN, BTN_DN held 60 cycles -> Down pulses at t0, t0+20, t0+28, t0+36, t0+44, ... Without the macro -> single pulse at t0.
//  6. RST pulsed while BTN_UP debounce cnt=2 and the button stays held -> no pulse during reset. One Up pulse 7 edges after RST falls.

Source files
------------

// File: rtl/up_dn_cmd_gen_pkg.sv
// Purpose: shared width and command encoding for the up/down counter command stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package up_dn_cmd_gen_pkg;

    // Counter / load-value width.
    localparam int CNT_W = 5;

    // Command encoding; a larger code means a higher priority.
    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DN   = 2'd2,
        CMD_LD   = 2'd3
    } cmd_e;

    // Load > Down > Up. Losing requests are simply dropped.
    function automatic cmd_e prio_cmd(input logic up, input logic dn, input logic ld);
        cmd_e c;
        c = CMD_NONE;
        if (ld)
            c = CMD_LD;
        else if (dn)
            c = CMD_DN;
        else if (up)
            c = CMD_UP;
        return c;
    endfunction

endpackage

// File: rtl/up_dn_cmd_gen_btn_debounce.sv
// Purpose: one pushbutton -> 2-flop sync -> debounced level (stable) -> one-cycle rise pulse.
// Latency: rise is high in the cycle after edge 1+DB_CYCLES (edge 0 = first edge sampling btn high).
// Backpressure: none; free-running, the pulse is never held or queued.
// Ports: clk/rst (async, active-high), btn raw input, stable debounced level, rise one-cycle press pulse.
module up_dn_cmd_gen_btn_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic rise
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : g_bad_db
        $error("DB_CYCLES must be at least 2");
    end

    logic          s1;
    logic          s2;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            rise     <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= btn;
            s2       <= s1;
            stable_d <= stable;
            // Registered so the pulse lands one cycle after stable rises.
            rise     <= stable & ~stable_d;
            // cnt counts consecutive cycles the synchronised level disagrees
            // with stable; any agreement restarts the count, so short glitches
            // never get through.
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/up_dn_cmd_gen.sv
// Purpose: turns raw up/down/load buttons and a 5-bit switch bank into clean one-cycle Up/Down/Load commands plus IN.
// Latency: command is high after edge 3+DB_CYCLES (edge 0 = first edge sampling the button high); all outputs registered.
// Backpressure: none; simultaneous requests are resolved Load > Down > Up and the losers are dropped.
// Ports: CLK, RST (async active-high), BTN_UP/BTN_DN/BTN_LD raw buttons, SW_IN raw switches,
//        Up/Down/Load one-hot-or-zero commands, IN load value (updated only when Load=1, held otherwise).
// Option: define AUTO_REPEAT_EN to auto-repeat Up/Down while held (first after REPEAT_DELAY, then every REPEAT_PERIOD).
module up_dn_cmd_gen
    import up_dn_cmd_gen_pkg::*;
#(
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BTN_UP,
    input  logic             BTN_DN,
    input  logic             BTN_LD,
    input  logic [CNT_W-1:0] SW_IN,
    output logic             Up,
    output logic             Down,
    output logic             Load,
    output logic [CNT_W-1:0] IN
);

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic             up_stable, up_rise;
    logic             dn_stable, dn_rise;
    logic             ld_stable, ld_rise;
    logic [CNT_W-1:0] sw_s1, sw_s2;
    logic             up_req, dn_req, ld_req;
    cmd_e             cmd;

    up_dn_cmd_gen_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_up (
        .clk(CLK), .rst(RST), .btn(BTN_UP), .stable(up_stable), .rise(up_rise)
    );
    up_dn_cmd_gen_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dn (
        .clk(CLK), .rst(RST), .btn(BTN_DN), .stable(dn_stable), .rise(dn_rise)
    );
    up_dn_cmd_gen_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_ld (
        .clk(CLK), .rst(RST), .btn(BTN_LD), .stable(ld_stable), .rise(ld_rise)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= SW_IN;
            sw_s2 <= sw_s1;
        end
    end

`ifdef AUTO_REPEAT_EN
    // Index 0 = up, 1 = down. rcnt holds cycles since the last pulse request
    // (0 = idle, not yet armed by an edge pulse). rfirst selects the longer
    // initial delay before the first repeat.
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] R_DELAY  = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_PERIOD = RW'(REPEAT_PERIOD);

    logic [1:0]    rep_stable;
    logic [1:0]    rep_rise;
    logic [1:0]    rfirst;
    logic [1:0]    rep;
    logic [RW-1:0] rcnt [2];

    assign rep_stable = {dn_stable, up_stable};
    assign rep_rise   = {dn_rise, up_rise};

    always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) begin
            rep[i] = rep_stable[i] && (rcnt[i] == (rfirst[i] ? R_DELAY : R_PERIOD));
        end
    end

    // The timer keeps running even when its pulse loses arbitration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rfirst  <= 2'b11;
            rcnt[0] <= '0;
            rcnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!rep_stable[i]) begin
                    rcnt[i]   <= '0;
                    rfirst[i] <= 1'b1;
                end else if (rep_rise[i]) begin
                    rcnt[i]   <= RW'(1);
                    rfirst[i] <= 1'b1;
                end else if (rep[i]) begin
                    rcnt[i]   <= RW'(1);
                    rfirst[i] <= 1'b0;
                end else if (rcnt[i] != '0) begin
                    rcnt[i] <= rcnt[i] + 1'b1;
                end
            end
        end
    end

    assign up_req = (up_rise & up_stable) | rep[0];
    assign dn_req = (dn_rise & dn_stable) | rep[1];
`else
    assign up_req = up_rise & up_stable;
    assign dn_req = dn_rise & dn_stable;
`endif

    // Load never repeats. rise only occurs while the level is still held.
    assign ld_req = ld_rise & ld_stable;
    assign cmd    = prio_cmd(up_req, dn_req, ld_req);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Up   <= 1'b0;
            Down <= 1'b0;
            Load <= 1'b0;
            IN   <= '0;
        end else begin
            Up   <= (cmd == CMD_UP);
            Down <= (cmd == CMD_DN);
            Load <= (cmd == CMD_LD);
            if (cmd == CMD_LD)
                IN <= sw_s2;
        end
    end

endmodule

// File: tb/tb_up_dn_cmd_gen.sv
// Purpose: self-checking bench for up_dn_cmd_gen (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, 10ns clock).
// Latency: n/a.
// Backpressure: n/a.
module tb_up_dn_cmd_gen;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_up, btn_dn, btn_ld;
    logic [4:0] sw;
    logic       Up, Down, Load;
    logic [4:0] IN;

    up_dn_cmd_gen #(.DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .CLK(clk), .RST(rst), .BTN_UP(btn_up), .BTN_DN(btn_dn), .BTN_LD(btn_ld),
        .SW_IN(sw), .Up(Up), .Down(Down), .Load(Load), .IN(IN)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Event-level view: each button's debounced level flips once it has seen
    // DB consecutive synchronised samples disagreeing with it; a press then
    // schedules an output pulse two edges later, and (optionally) repeat
    // pulses at absolute future edges, cancelled on release.
    int         edge_n = 0;
    logic [2:0] syn1 = '0, syn2 = '0, st = '0;
    logic [4:0] sw1 = '0, sw2 = '0;
    int         run[3] = '{0, 0, 0};
    int         rise_at[3] = '{-1, -1, -1};
    int         rep_at[3] = '{-1, -1, -1};
    logic       eu = 0, ed = 0, el = 0;
    logic [4:0] ein = '0;

    task automatic model_step();
        logic [2:0] syn;
        logic [2:0] r;
        edge_n++;
        if (rst) begin
            syn1 = '0; syn2 = '0; sw1 = '0; sw2 = '0; st = '0;
            for (int i = 0; i < 3; i++) begin
                run[i] = 0; rise_at[i] = -1; rep_at[i] = -1;
            end
            eu = 0; ed = 0; el = 0; ein = '0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            r[i] = (rise_at[i] == edge_n);
            if (rep_at[i] == edge_n) begin
                r[i] = 1'b1;
                rep_at[i] = edge_n + RP;
            end
        end
        el = r[2];
        ed = r[1] && !r[2];
        eu = r[0] && !r[1] && !r[2];
        if (el) ein = sw2;
        syn  = syn2;
        syn2 = syn1;
        syn1 = {btn_ld, btn_dn, btn_up};
        sw2  = sw1;
        sw1  = sw;
        for (int i = 0; i < 3; i++) begin
            if (syn[i] != st[i]) begin
                run[i]++;
                if (run[i] == DB) begin
                    st[i]  = syn[i];
                    run[i] = 0;
                    if (syn[i]) begin
                        rise_at[i] = edge_n + 2;
`ifdef AUTO_REPEAT_EN
                        if (i < 2) rep_at[i] = edge_n + 2 + RD;
`endif
                    end else begin
                        rep_at[i] = -1;
                    end
                end
            end else begin
                run[i] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare + event monitor ----------------
    bit         cmp_on = 0;
    int         up_cnt = 0, dn_cnt = 0, ld_cnt = 0;
    int         up_last = -1, dn_last = -1, ld_last = -1;
    logic [4:0] ld_in = '0;
    int         dn_q[$];

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            logic [7:0] exp_v;
            exp_v = rst ? 8'h00 : {eu, ed, el, ein};
            checks++;
            if ({Up, Down, Load, IN} !== exp_v) begin
                failures++;
                $display("FAIL cycle_cmp edge=%0d actual{Up,Down,Load,IN}=%b required=%b",
                         edge_n, {Up, Down, Load, IN}, exp_v);
            end
        end
        if (Up === 1'b1)   begin up_cnt++; up_last = edge_n; end
        if (Down === 1'b1) begin dn_cnt++; dn_last = edge_n; dn_q.push_back(edge_n); end
        if (Load === 1'b1) begin ld_cnt++; ld_last = edge_n; ld_in = IN; end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // advance n rising edges, then move 2ns off the edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int e0, e1, bu, bd, bl;
        int offs[6];
        rst = 1'b0; btn_up = 1'b1; btn_dn = 1'b1; btn_ld = 1'b1; sw = 5'h1F;

        // 1: reset clears outputs immediately, held with buttons pressed
        #7 rst = 1'b1;
        #1;
        chk("rst_up", int'(Up), 0);
        chk("rst_down", int'(Down), 0);
        chk("rst_load", int'(Load), 0);
        chk("rst_in", int'(IN), 0);
        cmp_on = 1;
        cyc(4);
        btn_up = 0; btn_dn = 0; btn_ld = 0;
        cyc(2);
        rst = 1'b0;
        cyc(5);

        // 2: 3-cycle glitch ignored; 10-cycle press gives one pulse after 7 edges
        bu = up_cnt;
        btn_up = 1; cyc(3); btn_up = 0; cyc(15);
        chk("glitch_no_up", up_cnt - bu, 0);
        bu = up_cnt;
        btn_up = 1; e0 = edge_n + 1; cyc(10); btn_up = 0; cyc(20);
        chk("up_once", up_cnt - bu, 1);
        chk("up_latency", up_last, e0 + 7);

        // 3: load captures switches, IN holds afterwards
        sw = 5'h0F; cyc(3);
        bl = ld_cnt;
        btn_ld = 1; e0 = edge_n + 1; cyc(10); btn_ld = 0; cyc(20);
        chk("ld_once", ld_cnt - bl, 1);
        chk("ld_latency", ld_last, e0 + 7);
        chk("ld_in_value", int'(ld_in), 'h0F);
        sw = 5'h03; cyc(10);
        chk("in_hold", int'(IN), 'h0F);

        // 4: up+down together -> down only; load while down held -> load only
        bu = up_cnt; bd = dn_cnt; bl = ld_cnt;
        btn_up = 1; btn_dn = 1; e0 = edge_n + 1;
        cyc(8);
        btn_ld = 1; cyc(10);
        btn_ld = 0; btn_up = 0; btn_dn = 0; cyc(25);
        chk("prio_dn_cnt", dn_cnt - bd, 1);
        chk("prio_up_cnt", up_cnt - bu, 0);
        chk("prio_ld_cnt", ld_cnt - bl, 1);
        chk("prio_dn_edge", dn_last, e0 + 7);
        chk("prio_ld_edge", ld_last, e0 + 15);

        // 5: long hold on down
        dn_q.delete();
        btn_dn = 1; e0 = edge_n + 1; cyc(60); btn_dn = 0; cyc(30);
`ifdef AUTO_REPEAT_EN
        offs = '{7, 27, 35, 43, 51, 59};
        chk("rep_count", dn_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rep_edge%0d", i), (i < dn_q.size()) ? dn_q[i] : -1, e0 + offs[i]);
        end
`else
        offs = '{7, 0, 0, 0, 0, 0};
        chk("hold_count", dn_q.size(), 1);
        chk("hold_edge", (dn_q.size() > 0) ? dn_q[0] : -1, e0 + offs[0]);
`endif

        // 6: reset mid-debounce (cnt=2) while held -> one pulse 7 edges after release of reset
        bu = up_cnt;
        btn_up = 1; cyc(4);
        rst = 1'b1; cyc(4);
        chk("no_up_in_rst", up_cnt - bu, 0);
        rst = 1'b0; e1 = edge_n + 1;
        cyc(15); btn_up = 0; cyc(15);
        chk("rst_repress_cnt", up_cnt - bu, 1);
        chk("rst_repress_edge", up_last, e1 + 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
